// File: rtl/l1_port_arbiter_if.sv
// rtl/l1_port_arbiter_if.sv - requester, L1 and status signals of the L1 port arbiter
// slave is the arbiter's view; master is the view of whatever drives the requesters and L1.
interface l1_port_arbiter_if;
   logic         rq0_valid;
   logic         rq0_write;
   logic [63:0]  rq0_addr;
   logic [63:0]  rq0_wdata;
   logic [2:0]   rq0_size;
   logic         rq0_ready;
   logic         rq0_done;
   logic [127:0] rq0_rdata;
   logic         rq0_err;

   logic         rq1_valid;
   logic         rq1_write;
   logic [63:0]  rq1_addr;
   logic [63:0]  rq1_wdata;
   logic [2:0]   rq1_size;
   logic         rq1_ready;
   logic         rq1_done;
   logic [127:0] rq1_rdata;
   logic         rq1_err;

   logic         c_read_in;
   logic         c_write_enable;
   logic [63:0]  c_addr;
   logic [63:0]  c_write_data;
   logic [2:0]   c_write_size;
   logic         c_done;
   logic [127:0] c_data;

   logic         busy;

   modport slave (
      input  rq0_valid, rq0_write, rq0_addr, rq0_wdata, rq0_size,
      output rq0_ready, rq0_done, rq0_rdata, rq0_err,
      input  rq1_valid, rq1_write, rq1_addr, rq1_wdata, rq1_size,
      output rq1_ready, rq1_done, rq1_rdata, rq1_err,
      output c_read_in, c_write_enable, c_addr, c_write_data, c_write_size,
      input  c_done, c_data,
      output busy
   );

   modport master (
      output rq0_valid, rq0_write, rq0_addr, rq0_wdata, rq0_size,
      input  rq0_ready, rq0_done, rq0_rdata, rq0_err,
      output rq1_valid, rq1_write, rq1_addr, rq1_wdata, rq1_size,
      input  rq1_ready, rq1_done, rq1_rdata, rq1_err,
      input  c_read_in, c_write_enable, c_addr, c_write_data, c_write_size,
      output c_done, c_data,
      input  busy
   );
endinterface

// File: rtl/l1_port_arbiter.sv
// rtl/l1_port_arbiter.sv - round-robin arbiter between instruction fetch (0) and data (1) ports into one L1 port
// One op in flight: IDLE accepts, ISSUE strobes L1, WAIT collects completion or times out, RESP reports.
module l1_port_arbiter #(
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst,
   l1_port_arbiter_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [7:0] LastWaitCount = 8'(TIMEOUT - 1);

   state_t        state_q;
   logic          last_grant_q;
   logic          id_q;
   logic [7:0]    cnt_q;
   logic [127:0]  rdata_q;
   logic          err_q;
   logic          write_q;
   logic [63:0]   addr_q;
   logic [63:0]   wdata_q;
   logic [2:0]    size_q;

   logic          gnt0;
   logic          gnt1;
   logic          write_d;
   logic [63:0]   addr_d;
   logic [63:0]   wdata_d;
   logic [2:0]    size_d;

   // Under contention the port not served last wins.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state_q == IDLE && !rst) begin
         gnt0 = bus.rq0_valid & (~bus.rq1_valid | last_grant_q);
         gnt1 = bus.rq1_valid & (~bus.rq0_valid | ~last_grant_q);
      end
      write_d = gnt1 ? bus.rq1_write : bus.rq0_write;
      addr_d  = gnt1 ? bus.rq1_addr  : bus.rq0_addr;
      wdata_d = gnt1 ? bus.rq1_wdata : bus.rq0_wdata;
      size_d  = gnt1 ? bus.rq1_size  : bus.rq0_size;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         cnt_q        <= 8'd0;
         rdata_q      <= 128'd0;
         err_q        <= 1'b0;
         write_q      <= 1'b0;
         addr_q       <= 64'd0;
         wdata_q      <= 64'd0;
         size_q       <= 3'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  write_q      <= write_d;
                  addr_q       <= addr_d;
                  wdata_q      <= wdata_d;
                  size_q       <= size_d;
                  id_q         <= gnt1;
                  last_grant_q <= gnt1;
                  state_q      <= ISSUE;
               end
            end
            ISSUE: begin
               cnt_q   <= 8'd0;
               state_q <= WAIT;
            end
            WAIT: begin
               // A completion on the final allowed cycle still counts as success.
               if (bus.c_done) begin
                  rdata_q <= bus.c_data;
                  err_q   <= 1'b0;
                  state_q <= RESP;
               end else if (cnt_q == LastWaitCount) begin
                  rdata_q <= 128'd0;
                  err_q   <= 1'b1;
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.rq0_ready      = gnt0;
   assign bus.rq1_ready      = gnt1;
   assign bus.rq0_done       = (state_q == RESP) & ~id_q & ~rst;
   assign bus.rq1_done       = (state_q == RESP) &  id_q & ~rst;
   assign bus.rq0_err        = bus.rq0_done & err_q;
   assign bus.rq1_err        = bus.rq1_done & err_q;
   assign bus.rq0_rdata      = rdata_q;
   assign bus.rq1_rdata      = rdata_q;
   assign bus.c_read_in      = (state_q == ISSUE) & ~rst;
   assign bus.c_write_enable = write_q;
   assign bus.c_addr         = addr_q;
   assign bus.c_write_data   = wdata_q;
   assign bus.c_write_size   = size_q;
   assign bus.busy           = (state_q != IDLE) & ~rst;
endmodule

// File: tb/tb_l1_port_arbiter.sv
// tb/tb_l1_port_arbiter.sv - table-driven bench for l1_port_arbiter
// Each record is one full transaction; hand sequences cover reset and stray completions.
module tb_l1_port_arbiter;
   localparam int TO = 4;

   typedef struct {
      logic         v0, w0;
      logic [63:0]  a0, wd0;
      logic [2:0]   s0;
      logic         v1, w1;
      logic [63:0]  a1, wd1;
      logic [2:0]   s1;
      int           dly;
      logic [127:0] cdata;
      logic         exp_id;
      logic         exp_err;
      logic [127:0] exp_rdata;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cur = 0;
   vec_t vecs [9];

   l1_port_arbiter_if bus ();

   l1_port_arbiter #(.TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL vec%0d %s: got %0h expected %0h", cur, name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic vec_t mk(input logic v0, input logic w0, input logic [63:0] a0,
                               input logic [63:0] wd0, input logic [2:0] s0,
                               input logic v1, input logic w1, input logic [63:0] a1,
                               input logic [63:0] wd1, input logic [2:0] s1,
                               input int dly, input logic [127:0] cdata,
                               input logic id, input logic err, input logic [127:0] rd);
      vec_t v;
      v.v0 = v0; v.w0 = w0; v.a0 = a0; v.wd0 = wd0; v.s0 = s0;
      v.v1 = v1; v.w1 = w1; v.a1 = a1; v.wd1 = wd1; v.s1 = s1;
      v.dly = dly; v.cdata = cdata;
      v.exp_id = id; v.exp_err = err; v.exp_rdata = rd;
      return v;
   endfunction

   task automatic clear_reqs();
      bus.rq0_valid = 0; bus.rq0_write = 0; bus.rq0_addr = 0; bus.rq0_wdata = 0; bus.rq0_size = 0;
      bus.rq1_valid = 0; bus.rq1_write = 0; bus.rq1_addr = 0; bus.rq1_wdata = 0; bus.rq1_size = 0;
   endtask

   task automatic check_fields(input string tag, input logic w, input logic [63:0] a,
                               input logic [63:0] wd, input logic [2:0] s);
      chk({tag, "_c_write_enable"}, 128'(bus.c_write_enable), 128'(w));
      chk({tag, "_c_addr"},         128'(bus.c_addr),         128'(a));
      chk({tag, "_c_write_data"},   128'(bus.c_write_data),   128'(wd));
      chk({tag, "_c_write_size"},   128'(bus.c_write_size),   128'(s));
   endtask

   task automatic run_vec(input vec_t v);
      logic        ew;
      logic [63:0] ea, ewd;
      logic [2:0]  es;
      int          kmax;
      ew  = v.exp_id ? v.w1  : v.w0;
      ea  = v.exp_id ? v.a1  : v.a0;
      ewd = v.exp_id ? v.wd1 : v.wd0;
      es  = v.exp_id ? v.s1  : v.s0;
      kmax = (v.dly >= 0 && v.dly < TO) ? v.dly : TO - 1;

      bus.rq0_valid = v.v0; bus.rq0_write = v.w0; bus.rq0_addr = v.a0;
      bus.rq0_wdata = v.wd0; bus.rq0_size = v.s0;
      bus.rq1_valid = v.v1; bus.rq1_write = v.w1; bus.rq1_addr = v.a1;
      bus.rq1_wdata = v.wd1; bus.rq1_size = v.s1;
      #1;
      chk("idle_ready0", 128'(bus.rq0_ready), 128'(v.exp_id == 1'b0));
      chk("idle_ready1", 128'(bus.rq1_ready), 128'(v.exp_id == 1'b1));
      chk("idle_busy", 128'(bus.busy), 128'd0);

      tick();
      chk("issue_c_read_in", 128'(bus.c_read_in), 128'd1);
      chk("issue_ready0", 128'(bus.rq0_ready), 128'd0);
      chk("issue_ready1", 128'(bus.rq1_ready), 128'd0);
      chk("issue_busy", 128'(bus.busy), 128'd1);
      check_fields("issue", ew, ea, ewd, es);

      tick();
      for (int k = 0; k <= kmax; k++) begin
         bus.c_done = (k == v.dly);
         bus.c_data = v.cdata;
         #1;
         chk("wait_c_read_in", 128'(bus.c_read_in), 128'd0);
         chk("wait_done0", 128'(bus.rq0_done), 128'd0);
         chk("wait_done1", 128'(bus.rq1_done), 128'd0);
         check_fields("wait", ew, ea, ewd, es);
         tick();
         bus.c_done = 0;
      end

      chk("resp_done0", 128'(bus.rq0_done), 128'(v.exp_id == 1'b0));
      chk("resp_done1", 128'(bus.rq1_done), 128'(v.exp_id == 1'b1));
      chk("resp_err0", 128'(bus.rq0_err), 128'(v.exp_id == 1'b0 && v.exp_err));
      chk("resp_err1", 128'(bus.rq1_err), 128'(v.exp_id == 1'b1 && v.exp_err));
      chk("resp_rdata0", bus.rq0_rdata, v.exp_rdata);
      chk("resp_rdata1", bus.rq1_rdata, v.exp_rdata);
      chk("resp_ready0", 128'(bus.rq0_ready), 128'd0);
      chk("resp_busy", 128'(bus.busy), 128'd1);
      check_fields("resp", ew, ea, ewd, es);

      tick();
      clear_reqs();
      #1;
      chk("post_done0", 128'(bus.rq0_done), 128'd0);
      chk("post_done1", 128'(bus.rq1_done), 128'd0);
      chk("post_busy", 128'(bus.busy), 128'd0);
   endtask

   initial begin
      vecs[0] = mk(1, 0, 64'h1000, 64'h0,  3'd0, 1, 1, 64'h2000, 64'h22, 3'd2, 0, 128'h10, 0, 0, 128'h10);
      vecs[1] = mk(1, 0, 64'h1100, 64'h0,  3'd0, 1, 0, 64'h2100, 64'h0,  3'd1, 1, 128'h11, 1, 0, 128'h11);
      vecs[2] = mk(1, 1, 64'h1200, 64'hA5, 3'd3, 1, 0, 64'h2200, 64'h0,  3'd0, 0, 128'h12, 0, 0, 128'h12);
      vecs[3] = mk(1, 0, 64'h1300, 64'h0,  3'd0, 1, 1, 64'h2300, 64'h77, 3'd1, 2, 128'h13, 1, 0, 128'h13);
      vecs[4] = mk(1, 0, 64'd4096, 64'h0,  3'd0, 0, 0, 64'h0,    64'h0,  3'd0, 1, 128'hAB, 0, 0, 128'hAB);
      vecs[5] = mk(0, 0, 64'h0,    64'h0,  3'd0, 1, 1, 64'd8192, 64'd8,  3'd3, 2, 128'h55, 1, 0, 128'h55);
      vecs[6] = mk(1, 0, 64'h3000, 64'h0,  3'd2, 0, 0, 64'h0,    64'h0,  3'd0, -1, 128'hDEAD, 0, 1, 128'h0);
      vecs[7] = mk(0, 0, 64'h0,    64'h0,  3'd0, 1, 0, 64'h4000, 64'h0,  3'd1, 3,
                   128'hCAFE_0000_1111_2222_3333_4444_5555_BEEF, 1, 0,
                   128'hCAFE_0000_1111_2222_3333_4444_5555_BEEF);
      vecs[8] = mk(1, 0, 64'h5000, 64'h0,  3'd0, 1, 0, 64'h6000, 64'h0,  3'd0, 0,
                   128'hFEED_FACE_0123_4567_89AB_CDEF_0F0F_F0F0, 0, 0,
                   128'hFEED_FACE_0123_4567_89AB_CDEF_0F0F_F0F0);

      clear_reqs();
      bus.c_done = 0;
      bus.c_data = 0;

      // Reset: request present but ready must stay low, everything cleared.
      cur = -1;
      rst = 1;
      bus.rq0_valid = 1;
      #1;
      chk("rst_ready0", 128'(bus.rq0_ready), 128'd0);
      tick();
      tick();
      chk("rst_busy", 128'(bus.busy), 128'd0);
      chk("rst_c_read_in", 128'(bus.c_read_in), 128'd0);
      chk("rst_done0", 128'(bus.rq0_done), 128'd0);
      chk("rst_err1", 128'(bus.rq1_err), 128'd0);
      chk("rst_rdata0", bus.rq0_rdata, 128'd0);
      check_fields("rst", 1'b0, 64'd0, 64'd0, 3'd0);
      rst = 0;
      clear_reqs();
      tick();

      for (int i = 0; i < 9; i++) begin
         cur = i;
         run_vec(vecs[i]);
      end

      // Stray completion while idle must not disturb anything.
      cur = 200;
      bus.c_done = 1;
      bus.c_data = 128'h1234_5678;
      tick();
      bus.c_done = 0;
      #1;
      chk("idle_cdone_done0", 128'(bus.rq0_done), 128'd0);
      chk("idle_cdone_done1", 128'(bus.rq1_done), 128'd0);
      chk("idle_cdone_busy", 128'(bus.busy), 128'd0);
      chk("idle_cdone_rdata", bus.rq0_rdata, vecs[8].exp_rdata);
      tick();
      chk("idle_cdone_c_read_in", 128'(bus.c_read_in), 128'd0);

      // Reset while waiting abandons the op; the late completion is ignored.
      cur = 300;
      bus.rq1_valid = 1;
      bus.rq1_addr  = 64'h7000;
      #1;
      chk("abort_ready1", 128'(bus.rq1_ready), 128'd1);
      tick();
      clear_reqs();
      tick();
      tick();
      chk("abort_in_wait_busy", 128'(bus.busy), 128'd1);
      rst = 1;
      tick();
      rst = 0;
      bus.c_done = 1;
      bus.c_data = 128'h77;
      #1;
      chk("abort_busy", 128'(bus.busy), 128'd0);
      chk("abort_done1", 128'(bus.rq1_done), 128'd0);
      chk("abort_c_addr", 128'(bus.c_addr), 128'd0);
      tick();
      chk("abort_late_done1", 128'(bus.rq1_done), 128'd0);
      chk("abort_late_rdata", bus.rq1_rdata, 128'd0);
      chk("abort_late_busy", 128'(bus.busy), 128'd0);
      bus.c_done = 0;
      tick();

      // last_grant is back at 1, so port 0 wins contention again.
      cur = 301;
      run_vec(mk(1, 0, 64'h8000, 64'h0, 3'd0, 1, 0, 64'h9000, 64'h0, 3'd0, 0, 128'h99, 0, 0, 128'h99));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
